// File: rtl/pc_unit_pkg.sv
//==============================================================================
// Module      : pc_unit_pkg
// Description : Shared definitions for the program-counter stage.
//               - Default values for PC width, reset vector and
//                 return-stack depth.
//               - Next-pc source select encoding.
//               - Helper that sizes the return-stack pointer.
//               Optional feature macro used by the slice: RET_STACK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pc_unit_pkg;

    localparam int          PC_W_DEF      = 16;
    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;
    localparam int          RS_DEPTH_DEF  = 4;

    // Source of the next fetch address.
    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,   // keep current pc
        SEL_INC  = 3'd1,   // sequential fetch
        SEL_JUMP = 3'd2,   // taken jump to target
        SEL_RET  = 3'd3,   // return to top of stack
        SEL_RVEC = 3'd4    // return on empty stack: restart at reset vector
    } pc_sel_e;

    // Pointer width for a stack of the given depth; never below one bit.
    function automatic int rs_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
//==============================================================================
// Module      : pc_ret_stack
// Description : Small LIFO holding return addresses for jump-and-link.
//               Push when full and pop when empty are ignored here; the
//               caller decides how to report them.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               push, pop       write / remove one entry (never both)
//               din             address to push
//               top             entry on top of the stack (valid if !empty)
//               full, empty     occupancy flags
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_ret_stack
    import pc_unit_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = rs_ptr_w(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W:0]   r_cnt;          // one extra bit so "full" is representable
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;

    assign full     = (r_cnt == (PTR_W + 1)'(DEPTH));
    assign empty    = (r_cnt == '0);
    assign w_wr_idx = r_cnt[PTR_W-1:0];
    assign w_rd_idx = PTR_W'(r_cnt - 1'b1);
    assign top      = r_mem[w_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (push && !full) begin
            r_mem[w_wr_idx] <= din;
            r_cnt           <= r_cnt + 1'b1;
        end else if (pop && !empty) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_unit.sv
//==============================================================================
// Module      : pc_unit
// Description : Program counter stage. Each cycle picks hold, jump to the
//               A-register target, return, or increment. Flags the
//               wrong-path fetch after a taken jump (flush) and detects the
//               jump-to-self halt idiom (halted, sticky).
//               Optional macro RET_STACK_EN adds a hardware return stack
//               (call pushes pc+1, ret pops); without it call/ret are
//               ignored and stack_err is tied low.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               stall           hold all state this cycle
//               load, target    taken jump and its address
//               call, ret       jump-and-link / return
//               pc, pc_valid    fetch address and its qualifier
//               flush           squash the fetch after a redirect
//               halted          sticky jump-to-self indication
//               stack_err       sticky stack overflow/underflow
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int              RS_DEPTH  = RS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            load,
    input  logic [PC_W-1:0] target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            halted,
    output logic            stack_err
);

    logic [PC_W-1:0] r_pc;
    logic            r_valid;
    logic            r_flush;
    logic            r_halted;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_nxt;
    logic            w_flush_nxt;
    logic            w_halt_set;
    pc_sel_e         w_sel;

    // Natural wrap at 2^PC_W.
    assign w_pc_inc = r_pc + PC_W'(1);

`ifdef RET_STACK_EN
    logic            r_stack_err;
    logic            w_err_set;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [PC_W-1:0] w_top;

    pc_ret_stack #(
        .W     (PC_W),
        .DEPTH (RS_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stack_err <= 1'b0;
        end else begin
            r_stack_err <= r_stack_err | w_err_set;
        end
    end

    assign stack_err = r_stack_err;
`else
    // call, ret and the stack depth have no effect in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{call, ret, 1'(RS_DEPTH % 2)};
    assign stack_err    = 1'b0;
`endif

    // Priority decode: not-yet-valid, stall, load, ret, increment.
    always_comb begin
        w_sel       = SEL_INC;
        w_flush_nxt = 1'b0;
        w_halt_set  = 1'b0;
`ifdef RET_STACK_EN
        w_err_set   = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        if (!r_valid) begin
            // First edge after reset release only raises pc_valid.
            w_sel = SEL_HOLD;
        end else if (stall) begin
            w_sel = SEL_HOLD;
        end else if (load) begin
            w_sel       = SEL_JUMP;
            w_flush_nxt = 1'b1;
            w_halt_set  = (target == r_pc);
`ifdef RET_STACK_EN
            if (call) begin
                // Overflowing push is dropped but the jump is still taken.
                if (w_full) begin
                    w_err_set = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end
`endif
        end
`ifdef RET_STACK_EN
        else if (ret) begin
            w_flush_nxt = 1'b1;
            if (w_empty) begin
                w_sel     = SEL_RVEC;
                w_err_set = 1'b1;
            end else begin
                w_sel = SEL_RET;
                w_pop = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_pc_nxt = w_pc_inc;
        case (w_sel)
            SEL_HOLD: w_pc_nxt = r_pc;
            SEL_JUMP: w_pc_nxt = target;
`ifdef RET_STACK_EN
            SEL_RET:  w_pc_nxt = w_top;
`endif
            SEL_RVEC: w_pc_nxt = RESET_VEC;
            default:  w_pc_nxt = w_pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_VEC;
            r_valid  <= 1'b0;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_valid  <= 1'b1;
            r_pc     <= w_pc_nxt;
            r_flush  <= w_flush_nxt;
            r_halted <= r_halted | w_halt_set;
        end
    end

    assign pc       = r_pc;
    assign pc_valid = r_valid;
    assign flush    = r_flush;
    assign halted   = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module      : tb_pc_unit
// Description : Directed self-checking bench for pc_unit. A behavioural
//               model predicts each cycle's outputs, queues them on a
//               scoreboard at drive time and compares after the edge.
//               Stack scenarios run when RET_STACK_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        stall  = 1'b0;
    logic        load   = 1'b0;
    logic        call   = 1'b0;
    logic        ret    = 1'b0;
    logic [15:0] target = 16'h0000;

    logic [15:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        halted;
    logic        stack_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic        valid;
        logic        flush;
        logic        halted;
        logic        serr;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_pc;
    logic        m_valid, m_flush, m_halt, m_err;
    logic [15:0] m_stack[$];

    pc_unit #(
        .PC_W      (16),
        .RESET_VEC (16'h0000),
        .RS_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .load      (load),
        .target    (target),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .halted    (halted),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_flush = 1'b0;
        m_halt  = 1'b0;
        m_err   = 1'b0;
        m_stack.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"},    pc,        m_pc);
        check({tag, "_valid"}, pc_valid,  16'(m_valid));
        check({tag, "_flush"}, flush,     16'(m_flush));
        check({tag, "_halt"},  halted,    16'(m_halt));
        check({tag, "_serr"},  stack_err, 16'(m_err));
    endtask

    // Drive one cycle, predict the result, compare after the edge.
    task automatic step(input string tag, input logic s, input logic l,
                        input logic [15:0] t, input logic c, input logic r);
        exp_t e;
        stall  = s;
        load   = l;
        target = t;
        call   = c;
        ret    = r;
        if (!m_valid) begin
            m_valid = 1'b1;
        end else if (s) begin
            m_flush = 1'b0;
        end else if (l) begin
            if (t == m_pc) m_halt = 1'b1;
`ifdef RET_STACK_EN
            if (c) begin
                if (m_stack.size() == 4) m_err = 1'b1;
                else m_stack.push_back(m_pc + 16'h0001);
            end
`endif
            m_pc    = t;
            m_flush = 1'b1;
        end
`ifdef RET_STACK_EN
        else if (r) begin
            if (m_stack.size() == 0) begin
                m_pc  = 16'h0000;
                m_err = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
            end
            m_flush = 1'b1;
        end
`endif
        else begin
            m_pc    = m_pc + 16'h0001;
            m_flush = 1'b0;
        end
        sb.push_back('{pc: m_pc, valid: m_valid, flush: m_flush, halted: m_halt, serr: m_err});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_pc"},    pc,        e.pc);
        check({tag, "_valid"}, pc_valid,  16'(e.valid));
        check({tag, "_flush"}, flush,     16'(e.flush));
        check({tag, "_halt"},  halted,    16'(e.halted));
        check({tag, "_serr"},  stack_err, 16'(e.serr));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset and release between edges (edges at 5, 15, 25, ...).
        #12;
        check_state("reset");
        rst_n = 1'b1;
        #1;
        check("release_valid0", pc_valid, 16'h0000);

        // Sequential fetch after release.
        idle("first_edge");
        idle("inc1");
        idle("inc2");
        idle("inc3");
        check("seq_pc3", pc, 16'h0003);
        idle("inc4");
        idle("inc5");
        check("pc5", pc, 16'h0005);

        // Taken jump, flush for exactly one cycle.
        step("jump40", 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
        check("jump40_lit", pc, 16'h0040);
        check("jump40_fl",  flush, 16'h0001);
        idle("after40");
        check("after40_lit", pc, 16'h0041);

        // Wrap from all-ones.
        step("jumpffff", 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        idle("wrap");
        check("wrap_lit", pc, 16'h0000);

        // Stall overrides load.
        step("jump10", 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0);
        step("stall_ld", 1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
        check("stall_pc",    pc,    16'h0010);
        check("stall_flush", flush, 16'h0000);
        step("stall2", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);

        // call/ret without load: ret alone, call alone.
        step("ret_alone",  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step("call_alone", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

        // Jump-to-self halt detection, sticky through later jumps.
        step("jump12", 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
        step("self12", 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
        check("halt_lit",  halted, 16'h0001);
        check("halt_pc",   pc,     16'h0012);
        step("jump30", 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
        idle("post_halt");
        check("halt_sticky", halted, 16'h0001);

`ifdef RET_STACK_EN
        // Call and return.
        step("jump3",   1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
        step("call100", 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0);
        idle("in_sub");
        step("ret1", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check("ret_lit",   pc,    16'h0004);
        check("ret_flush", flush, 16'h0001);
        // Five nested calls overflow a 4-deep stack.
        for (int i = 0; i < 5; i++) begin
            step("nest", 1'b0, 1'b1, 16'h0200 + 16'(i * 16), 1'b1, 1'b0);
        end
        check("ovf_lit", stack_err, 16'h0001);
        // load and ret together: load wins, stack untouched.
        step("ld_ret", 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("unwind", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        end
        step("underflow", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        // Build depth 2 ahead of the mid-stall reset.
        step("call_a", 1'b0, 1'b1, 16'h0300, 1'b1, 1'b0);
        step("call_b", 1'b0, 1'b1, 16'h0310, 1'b1, 1'b0);
`endif

        // Asynchronous reset in the middle of a stall.
        step("pre_rst_stall", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        #2;
        rst_n = 1'b1;
        #1;
        check("rerelease_valid0", pc_valid, 16'h0000);
        idle("re_first");
`ifdef RET_STACK_EN
        // Stack must be empty after reset: return underflows.
        step("post_rst_ret", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
`endif
        idle("re_inc");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
